// File: rtl/cmn_params.sv
// Common datapath widths shared across the MAC blocks.
//   N_SYMBOLS : byte lanes per AXI-Stream beat
//   W_SYMBOL  : bits per byte lane
package cmn_params;
  localparam int N_SYMBOLS = 4;
  localparam int W_SYMBOL  = 8;
endpackage

// File: rtl/mac_params.sv
// MAC-level types: layout of one RX packet FIFO entry.
//   W_FIFO_ENTRY    : bits per stored beat {last, keep, data}
//   rx_fifo_entry_t : packed view of one stored beat
package mac_params;
  import cmn_params::*;

  localparam int W_FIFO_ENTRY = 1 + N_SYMBOLS + N_SYMBOLS*W_SYMBOL;

  typedef struct packed {
    logic                          last;
    logic [N_SYMBOLS-1:0]          keep;
    logic [N_SYMBOLS*W_SYMBOL-1:0] data;
  } rx_fifo_entry_t;
endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array has no reset; rd_data only updates when rd_en is high, so a
// stalled read stage keeps its word.
//   i_clk   : clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr/rd_data : read port, data valid the cycle after rd_en
module sdp_ram #(
  parameter  int DEPTH  = 512,
  parameter  int WIDTH  = 8,
  localparam int W_ADDR = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              wr_en,
  input  logic [W_ADDR-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [W_ADDR-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data      <= mem[rd_addr];
  end
endmodule

// File: rtl/mac_rx_pkt_fifo.sv
// Store-and-forward RX frame buffer behind the MAC. Beats are written into a
// circular RAM; a frame becomes readable only once its tlast lands without
// tuser. Errored or overflowing frames are discarded by rewinding wr_ptr to
// commit_ptr.
//   i_clk, i_reset_n      : clock, async active-low reset
//   s_axis_*              : MAC input stream (no tready)
//   m_axis_*              : consumer output stream
//   o_drop_err/o_drop_ovf : one-cycle discard pulses
//   o_cnt_good/err/ovf    : saturating frame statistics
module mac_rx_pkt_fifo
  import cmn_params::*;
  import mac_params::*;
#(
  parameter  int DEPTH  = 512,
  parameter  int W_STAT = 16,
  localparam int W_ADDR = $clog2(DEPTH)
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          s_axis_tvalid,
  input  logic [N_SYMBOLS-1:0]          s_axis_tkeep,
  input  logic [N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [N_SYMBOLS-1:0]          m_axis_tkeep,
  output logic [N_SYMBOLS*W_SYMBOL-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          o_drop_err,
  output logic                          o_drop_ovf,
  output logic [W_STAT-1:0]             o_cnt_good,
  output logic [W_STAT-1:0]             o_cnt_err,
  output logic [W_STAT-1:0]             o_cnt_ovf
);
  localparam logic [W_ADDR:0] FULL_LVL = (W_ADDR+1)'(DEPTH);

  function automatic logic [W_STAT-1:0] sat_inc(input logic [W_STAT-1:0] v);
    return (&v) ? v : v + W_STAT'(1);
  endfunction

  // rd_ptr advances on consumer transfer, so beats parked in the read
  // stages still count as occupied. fetch_ptr addresses the RAM read.
  logic [W_ADDR:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
  logic            drop;

  logic            full, end_beat;
  logic            wr_en, drop_nxt, err_p, ovf_p, good_p;
  logic [W_ADDR:0] wr_nxt, commit_nxt;
  rx_fifo_entry_t  wr_entry;

  assign full     = (wr_ptr - rd_ptr) == FULL_LVL;
  assign end_beat = s_axis_tlast | s_axis_tuser;
  assign wr_entry = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};

  // Write-side decode; overflow is checked before tuser so it wins.
  always_comb begin
    wr_en      = 1'b0;
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    drop_nxt   = drop;
    err_p      = 1'b0;
    ovf_p      = 1'b0;
    good_p     = 1'b0;
    if (s_axis_tvalid) begin
      if (drop) begin
        if (end_beat) begin
          drop_nxt = 1'b0;
          ovf_p    = 1'b1;
        end
      end else if (full) begin
        wr_nxt = commit_ptr;
        if (end_beat) ovf_p    = 1'b1;
        else          drop_nxt = 1'b1;
      end else if (s_axis_tuser) begin
        wr_nxt = commit_ptr;
        err_p  = 1'b1;
      end else begin
        wr_en  = 1'b1;
        wr_nxt = wr_ptr + 1'b1;
        if (s_axis_tlast) begin
          commit_nxt = wr_nxt;
          good_p     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop       <= 1'b0;
      o_drop_err <= 1'b0;
      o_drop_ovf <= 1'b0;
      o_cnt_good <= '0;
      o_cnt_err  <= '0;
      o_cnt_ovf  <= '0;
    end else begin
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      drop       <= drop_nxt;
      o_drop_err <= err_p;
      o_drop_ovf <= ovf_p;
      if (good_p) o_cnt_good <= sat_inc(o_cnt_good);
      if (err_p)  o_cnt_err  <= sat_inc(o_cnt_err);
      if (ovf_p)  o_cnt_ovf  <= sat_inc(o_cnt_ovf);
    end
  end

  // Read side: vld_pipe[0] = RAM read stage, vld_pipe[1] = output register.
  logic [1:0]     vld_pipe;
  logic           ram_rd, out_ld, xfer;
  rx_fifo_entry_t ram_q, out_q;

  assign xfer   = vld_pipe[1] & m_axis_tready;
  assign out_ld = vld_pipe[0] & (~vld_pipe[1] | m_axis_tready);
  assign ram_rd = (fetch_ptr != commit_ptr) & (~vld_pipe[0] | out_ld);

  sdp_ram #(.DEPTH(DEPTH), .WIDTH(W_FIFO_ENTRY)) u_ram (
    .i_clk   (i_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[W_ADDR-1:0]),
    .wr_data (wr_entry),
    .rd_en   (ram_rd),
    .rd_addr (fetch_ptr[W_ADDR-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fetch_ptr <= '0;
      rd_ptr    <= '0;
      vld_pipe  <= '0;
      out_q     <= '0;
    end else begin
      if (ram_rd) fetch_ptr <= fetch_ptr + 1'b1;
      if (xfer)   rd_ptr    <= rd_ptr + 1'b1;
      if (out_ld) out_q     <= ram_q;
      vld_pipe[0] <= ram_rd | (vld_pipe[0] & ~out_ld);
      vld_pipe[1] <= out_ld | (vld_pipe[1] & ~xfer);
    end
  end

  assign m_axis_tvalid = vld_pipe[1];
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tdata  = out_q.data;
endmodule

// File: tb/tb_mac_rx_pkt_fifo.sv
module tb_mac_rx_pkt_fifo;
  import cmn_params::*;
  import mac_params::*;

  localparam int DEPTH  = 16;
  localparam int W_STAT = 16;
  localparam int W_E    = W_FIFO_ENTRY;

  logic                          i_clk = 1'b0;
  logic                          i_reset_n;
  logic                          s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic [N_SYMBOLS-1:0]          s_axis_tkeep;
  logic [N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata;
  logic                          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [N_SYMBOLS-1:0]          m_axis_tkeep;
  logic [N_SYMBOLS*W_SYMBOL-1:0] m_axis_tdata;
  logic                          o_drop_err, o_drop_ovf;
  logic [W_STAT-1:0]             o_cnt_good, o_cnt_err, o_cnt_ovf;

  mac_rx_pkt_fifo #(.DEPTH(DEPTH), .W_STAT(W_STAT)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .o_drop_err(o_drop_err), .o_drop_ovf(o_drop_ovf),
    .o_cnt_good(o_cnt_good), .o_cnt_err(o_cnt_err), .o_cnt_ovf(o_cnt_ovf)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: beats committed but not yet handed to the consumer,
  // the frame being received, and frame-level bookkeeping.
  logic [W_E-1:0] exp_q[$];
  logic [W_E-1:0] cur[$];
  bit             m_drop;
  int             m_good, m_err, m_ovf;
  bit             stall_prev;
  logic [W_E-1:0] held;
  bit             rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    exp_q.delete(); cur.delete();
    m_drop = 0; m_good = 0; m_err = 0; m_ovf = 0; stall_prev = 0;
  endtask

  // One clock cycle: drive an input beat, predict, clock, check.
  task automatic cyc(input bit v, input bit l, input bit u);
    logic [W_E-1:0] e, got;
    bit xf, ep, op, full;
    ep = 0; op = 0;
    s_axis_tvalid = v; s_axis_tlast = l; s_axis_tuser = u;
    s_axis_tkeep  = N_SYMBOLS'($urandom_range(0, (1 << N_SYMBOLS) - 1));
    s_axis_tdata  = $urandom();
    m_axis_tready = rdy;
    e   = {l, s_axis_tkeep, s_axis_tdata};
    got = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    xf  = m_axis_tvalid && rdy;
    if (stall_prev) begin
      chk("hold_vld", m_axis_tvalid, 1);
      chk("hold_beat", got, held);
    end
    // Buffer occupancy before this edge's transfer is what counts.
    full = (exp_q.size() + cur.size()) >= DEPTH;
    if (v) begin
      if (m_drop) begin
        if (l || u) begin m_drop = 0; op = 1; end
      end else if (full) begin
        cur.delete();
        if (l || u) op = 1; else m_drop = 1;
      end else if (u) begin
        cur.delete(); ep = 1;
      end else begin
        cur.push_back(e);
        if (l) begin
          foreach (cur[i]) exp_q.push_back(cur[i]);
          cur.delete();
          m_good = sat(m_good);
        end
      end
    end
    if (ep) m_err = sat(m_err);
    if (op) m_ovf = sat(m_ovf);
    if (xf) begin
      if (exp_q.size() == 0) chk("unexpected_beat_vld", m_axis_tvalid, 0);
      else chk("out_beat", got, exp_q.pop_front());
    end
    stall_prev = m_axis_tvalid && !rdy;
    held = got;
    @(posedge i_clk); #1;
    chk("drop_err", o_drop_err, ep);
    chk("drop_ovf", o_drop_ovf, op);
    chk("cnt_good", o_cnt_good, m_good);
    chk("cnt_err",  o_cnt_err,  m_err);
    chk("cnt_ovf",  o_cnt_ovf,  m_ovf);
  endtask

  // err_at: beat index carrying tuser (0 = clean frame, tlast on last beat).
  task automatic send_frame(input int len, input int err_at);
    for (int b = 1; b <= len; b++) begin
      if (err_at != 0 && b == err_at) begin cyc(1, 0, 1); return; end
      cyc(1, b == len, 0);
    end
  endtask

  task automatic drain();
    rdy = 1;
    for (int i = 0; i < 200 && (exp_q.size() > 0 || m_axis_tvalid); i++) cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("drain_left", exp_q.size(), 0);
    chk("drain_vld", m_axis_tvalid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vld"},  m_axis_tvalid, 0);
    chk({tag, "_beat"}, {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
    chk({tag, "_pulses"}, {o_drop_err, o_drop_ovf}, 0);
    chk({tag, "_cnts"}, {o_cnt_good, o_cnt_err, o_cnt_ovf}, 0);
  endtask

  initial begin
    i_reset_n = 0; rdy = 1;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tuser = 0;
    s_axis_tkeep = '0; s_axis_tdata = '0; m_axis_tready = 1;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge i_clk); #1;
    i_reset_n = 1;
    cyc(0, 0, 0);

    // 1: 16-beat good frame, latency of first beat.
    rdy = 1;
    send_frame(16, 0);
    chk("t1_lat0", m_axis_tvalid, 0);
    cyc(0, 0, 0);
    chk("t1_lat1", m_axis_tvalid, 0);
    cyc(0, 0, 0);
    chk("t1_lat2", m_axis_tvalid, 1);
    drain();
    chk("t1_good", o_cnt_good, 1);

    // 2: errored frame (tuser on beat 5), then a 4-beat good frame.
    send_frame(5, 5);
    send_frame(4, 0);
    drain();
    chk("t2_err", o_cnt_err, 1);
    chk("t2_good", o_cnt_good, 2);

    // 3: stalled output, 10-beat frame then 8-beat frame that overflows.
    rdy = 0;
    send_frame(10, 0);
    for (int b = 1; b <= 8; b++) begin
      cyc(1, b == 8, 0);
      if (b == 7) chk("t3_no_pulse_b7", o_drop_ovf, 0);
    end
    chk("t3_ovf_pulse", o_drop_ovf, 1);
    chk("t3_ovf", o_cnt_ovf, 1);
    drain();
    chk("t3_good", o_cnt_good, 3);

    // 4: 20-beat frame into empty FIFO is always an overflow.
    send_frame(20, 0);
    chk("t4_ovf", o_cnt_ovf, 2);
    cyc(0, 0, 0); cyc(0, 0, 0);
    chk("t4_no_out", m_axis_tvalid, 0);
    drain();

    // 5: back-to-back 3-beat frames with random tready, across wrap.
    for (int f = 0; f < 48; f++) begin
      for (int b = 1; b <= 3; b++) begin
        rdy = ($urandom_range(0, 9) < 8);
        cyc(1, b == 3, 0);
      end
      for (int g = $urandom_range(1, 2); g > 0; g--) begin
        rdy = ($urandom_range(0, 9) < 8);
        cyc(0, 0, 0);
      end
    end
    drain();

    // 6: async reset mid-frame with output stalled.
    rdy = 0;
    send_frame(3, 0);
    cyc(1, 0, 0); cyc(1, 0, 0);
    chk("t6_pre_vld", m_axis_tvalid, 1);
    #2 i_reset_n = 0;
    #1 check_all_zero("t6_async");
    model_reset();
    s_axis_tvalid = 0;
    @(posedge i_clk); #1;
    i_reset_n = 1;
    rdy = 1;
    cyc(0, 0, 0);
    send_frame(4, 0);
    drain();
    chk("t6_good", o_cnt_good, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
